// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a load/store client and dmem_ctrl.
// The client is the master; the memory controller is the slave.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller: byte/half/word loads and stores with a
// fixed response latency, alignment/range checking and a cleared-on-reset array.
module dmem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_dm_n,
    dmem_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [31:0]       mem_q [DEPTH];

    logic              acc_err;
    logic              do_access;
    logic              mem_we;
    logic              op_write;
    logic [1:0]        op_size;
    logic              op_uns;
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [ADDR_W-1:0] op_idx;
    logic [31:0]       op_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;
    logic [3:0]        be;
    logic [31:0]       wr_data;

    // With LATENCY=0 the access happens on the accept edge itself, so the
    // operation comes straight from the request bus rather than the latches.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_write = bus.req_write;
            op_size  = bus.req_size;
            op_uns   = bus.req_unsigned;
            op_addr  = bus.req_addr[ADDR_W+1:0];
            op_wdata = bus.req_wdata;
        end else begin
            op_write = write_q;
            op_size  = size_q;
            op_uns   = uns_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
        op_idx  = op_addr[ADDR_W+1:2];
        op_word = mem_q[op_idx];
    end

    always_comb begin
        case (bus.req_size)
            2'b11:   acc_err = 1'b1;
            2'b01:   acc_err = bus.req_addr[0];
            2'b10:   acc_err = (bus.req_addr[1:0] != 2'b00);
            default: acc_err = 1'b0;
        endcase
        if ((bus.req_addr >> (ADDR_W + 2)) != 32'd0) acc_err = 1'b1;
    end

    always_comb begin
        ld_byte = op_word[8*op_addr[1:0] +: 8];
        ld_half = op_addr[1] ? op_word[31:16] : op_word[15:0];
        case (op_size)
            2'b00:   load_data = op_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_data = op_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = op_word;
        endcase

        case (op_size)
            2'b00: begin
                be      = 4'b0001 << op_addr[1:0];
                wr_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be      = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{op_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = op_wdata;
            end
        endcase
    end

    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        do_access   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr[ADDR_W+1:0];
                    wdata_d = bus.req_wdata;
                    if (acc_err) begin
                        state_d     = S_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (LATENCY == 0) begin
                        state_d   = S_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_access) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = op_write ? '0 : load_data;
        end
        mem_we = do_access && op_write;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_dm_n) begin
        if (!rst_dm_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // NOTE: the array must read as zero after reset, so it is built from
    // resettable flops rather than an inferred RAM macro.
    always_ff @(posedge clk or negedge rst_dm_n) begin
        if (!rst_dm_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[op_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = rst_dm_n && (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
